vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter VRAM_AW, default 15, VRAM address width; all addresses SHALL wrap modulo 2^VRAM_AW.
REQ-002 Port pixel_clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port reset_n  in  1  reset, asynchronous, active-low.
REQ-004 Port disp_req  in  1  display read strobe, one cycle per fetch.
REQ-005 Port disp_addr  in  VRAM_AW  display fetch address, valid with disp_req.
REQ-006 Port disp_data  out  8  last display fetch result, held until next display fetch completes.
REQ-007 Port cpu_req  in  1  CPU access strobe, one cycle, honoured only in IDLE.
REQ-008 Port cpu_we  in  1  1 = write, 0 = read, valid with cpu_req.
REQ-009 Port cpu_addr  in  VRAM_AW  CPU address, valid with cpu_req.
REQ-010 Port cpu_wdata  in  8  CPU write data, valid with cpu_req.
REQ-011 Port cpu_rdata  out  8  CPU read result, valid in the cpu_ack cycle and held after it.
REQ-012 Port cpu_wait  out  1  CPU stall request.
REQ-013 Port cpu_ack  out  1  one-cycle completion pulse.
REQ-014 Port ram_addr  out  VRAM_AW  registered synchronous-RAM address.
REQ-015 Port ram_we  out  1  registered RAM write enable.
REQ-016 Port ram_wdata  out  8  registered RAM write data.
REQ-017 Port ram_rdata  in  8  RAM read data, valid the cycle after ram_addr is presented.

Function
REQ-018 One RAM slot per cycle; the slot owner is chosen at each edge: disp_req=1 -> DISP; else state PEND -> CPU; else IDLE slot (ram_we=0, ram_addr held).
REQ-019 Display SHALL have absolute priority; a disp_req is never dropped or delayed, including back-to-back requests.
REQ-020 Display latency: disp_req in cycle N -> ram_addr=disp_addr in N+1 -> disp_data updated, visible from N+3.
REQ-021 CPU FSM states: IDLE, PEND, ISSUED, RDWAIT, ACK.
REQ-022 IDLE: cpu_req=1 captures cpu_we/cpu_addr/cpu_wdata into a one-entry buffer -> PEND.
REQ-023 PEND: leaves only on a CPU slot (-> ISSUED); each disp_req adds exactly one cycle.
REQ-024 ISSUED: RAM op visible (write: ram_we=1, ram_wdata=buffer); next state is ACK for a write, RDWAIT for a read.
REQ-025 RDWAIT: ram_rdata registered into cpu_rdata -> ACK.
REQ-026 ACK: cpu_ack=1 for one cycle -> IDLE.
REQ-027 Uncontended latency: cpu_req in cycle N -> write ack in N+3, read ack in N+4.
REQ-028 cpu_wait = cpu_req OR (state not IDLE and not ACK); it deasserts in the cpu_ack cycle.
REQ-029 A cpu_req outside IDLE SHALL be ignored, with no buffer change and no RAM side effect.
REQ-030 A CPU write and a display read to the same address in adjacent slots SHALL give the display the RAM's read-after-write result, with no reordering by the arbiter.
REQ-031 ram_we SHALL be 1 only in a CPU write slot, never in DISP or IDLE slots.

Reset
REQ-032 While reset_n=0: state IDLE; buffer, ram_addr, ram_wdata, disp_data and cpu_rdata are 0; ram_we, cpu_ack and cpu_wait are 0.
REQ-033 Reset asserted mid-operation SHALL abort the CPU op and force ram_we=0 immediately, without waiting for a clock edge; no ack is issued.
REQ-034 After reset release, the first edge SHALL accept disp_req/cpu_req normally.

Structure
REQ-035 Shared package laser310_vram_pkg SHALL hold the CPU state enum, the slot-owner encoding (IDLE/DISP/CPU) and the VRAM_AW default.
REQ-036 Single module, no sub-module; the slot owner SHALL be delayed through a 2-stage pipeline to steer ram_rdata to disp_data or cpu_rdata.

Verification
REQ-037 Write, no contention: cpu_req/we=1, addr=0x7000, wdata=0xA5 at N -> ram_we=1 with addr 0x7000 in N+2; cpu_ack in N+3; cpu_wait high N..N+2.
REQ-038 Read, no contention: RAM holds 0x3C at 0x0010; cpu_req/we=0 at N -> cpu_ack and cpu_rdata=0x3C in N+4.
REQ-039 Contention: cpu write pending (PEND) while disp_req is asserted for 3 consecutive cycles, addrs 0x0100..0x0102 -> all three display results are correct; CPU ram_we is delayed by 3 cycles; ack arrives at N+6.
REQ-040 Display fetch: disp_req, addr 0x0020 (data 0x41) at N -> disp_data=0x41 from N+3, held while no further disp_req.
REQ-041 Reset mid-write: reset_n low in the ISSUED cycle -> ram_we=0 immediately; no cpu_ack; state IDLE; a fresh cpu_req after release completes normally.
REQ-042 Wrap and ignore: VRAM_AW=11 with cpu_addr=0x0805 writes 0x005; a second cpu_req during PEND leaves the buffer unchanged and gets no extra ack.

Source files
------------

// File: rtl/laser310_vram_pkg.sv
// Shared types for the Laser 310 VRAM arbiter: CPU access states, RAM slot owners
// and the default VRAM address width.
package laser310_vram_pkg;

    localparam int VRAM_AW_DEFAULT = 15;

    typedef enum logic [2:0] {
        CPU_IDLE,
        CPU_PEND,
        CPU_ISSUED,
        CPU_RDWAIT,
        CPU_ACK
    } cpu_state_e;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_DISP,
        SLOT_CPU
    } slot_owner_e;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: the display owns any slot it asks for, and the CPU
// gets a one-entry buffered access in the slots the display leaves free.
//
// state  | meaning
// IDLE   | no CPU access in flight, cpu_req accepted
// PEND   | access buffered, waiting for a slot without disp_req
// ISSUED | CPU access on the RAM port this cycle
// RDWAIT | RAM read data arriving, captured into cpu_rdata
// ACK    | cpu_ack pulse, back to IDLE next cycle
module vram_arbiter
    import laser310_vram_pkg::*;
#(
    parameter int VRAM_AW = VRAM_AW_DEFAULT
) (
    input  logic               pixel_clock,
    input  logic               reset_n,
    input  logic               disp_req,
    input  logic [VRAM_AW-1:0] disp_addr,
    output logic [7:0]         disp_data,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [VRAM_AW-1:0] cpu_addr,
    input  logic [7:0]         cpu_wdata,
    output logic [7:0]         cpu_rdata,
    output logic               cpu_wait,
    output logic               cpu_ack,
    output logic [VRAM_AW-1:0] ram_addr,
    output logic               ram_we,
    output logic [7:0]         ram_wdata,
    input  logic [7:0]         ram_rdata
);

    cpu_state_e         state_q,     state_d;
    logic               buf_we_q,    buf_we_d;
    logic [VRAM_AW-1:0] buf_addr_q,  buf_addr_d;
    logic [7:0]         buf_wdata_q, buf_wdata_d;
    logic [VRAM_AW-1:0] ram_addr_q,  ram_addr_d;
    logic               ram_we_q,    ram_we_d;
    logic [7:0]         ram_wdata_q, ram_wdata_d;
    slot_owner_e        owner1_q,    owner1_d;
    slot_owner_e        owner2_q,    owner2_d;
    logic [7:0]         disp_data_q, disp_data_d;
    logic [7:0]         cpu_rdata_q, cpu_rdata_d;
    slot_owner_e        slot;

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CPU_IDLE;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            owner1_q    <= SLOT_IDLE;
            owner2_q    <= SLOT_IDLE;
            disp_data_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            buf_we_q    <= buf_we_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            owner1_q    <= owner1_d;
            owner2_q    <= owner2_d;
            disp_data_q <= disp_data_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    always_comb begin
        slot        = SLOT_IDLE;
        state_d     = state_q;
        buf_we_d    = buf_we_q;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        disp_data_d = disp_data_q;
        cpu_rdata_d = cpu_rdata_q;

        if (disp_req) begin
            slot = SLOT_DISP;
        end else if (state_q == CPU_PEND) begin
            slot = SLOT_CPU;
        end

        unique case (state_q)
            CPU_IDLE: begin
                if (cpu_req) begin
                    buf_we_d    = cpu_we;
                    buf_addr_d  = cpu_addr;
                    buf_wdata_d = cpu_wdata;
                    state_d     = CPU_PEND;
                end
            end
            CPU_PEND: begin
                if (slot == SLOT_CPU) begin
                    state_d = CPU_ISSUED;
                end
            end
            CPU_ISSUED: state_d = buf_we_q ? CPU_ACK : CPU_RDWAIT;
            CPU_RDWAIT: state_d = CPU_ACK;
            CPU_ACK:    state_d = CPU_IDLE;
            default:    state_d = CPU_IDLE;
        endcase

        // An idle slot keeps the previous address on the RAM port.
        unique case (slot)
            SLOT_DISP: begin
                ram_addr_d = disp_addr;
            end
            SLOT_CPU: begin
                ram_addr_d = buf_addr_q;
                ram_we_d   = buf_we_q;
                if (buf_we_q) begin
                    ram_wdata_d = buf_wdata_q;
                end
            end
            default: ;
        endcase

        owner1_d = slot;
        owner2_d = owner1_q;

        // owner2_q lines up with the cycle in which ram_rdata answers that slot.
        if (owner2_q == SLOT_DISP) begin
            disp_data_d = ram_rdata;
        end
        if (owner2_q == SLOT_CPU && state_q == CPU_RDWAIT) begin
            cpu_rdata_d = ram_rdata;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign disp_data = disp_data_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = (state_q == CPU_ACK);
    assign cpu_wait  = reset_n & (cpu_req | ((state_q != CPU_IDLE) & (state_q != CPU_ACK)));

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed latency cases plus random display/CPU traffic
// scored against a slot-order reference model and a synchronous RAM model.
module tb_vram_arbiter;

    localparam int AW   = 15;
    localparam int SAW  = 11;
    localparam int MAXC = 4096;

    logic          pixel_clock = 1'b0;
    logic          reset_n;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [7:0]    disp_data;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic [7:0]    cpu_rdata;
    logic          cpu_wait;
    logic          cpu_ack;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata = 8'h00;

    logic           s_disp_req;
    logic [SAW-1:0] s_disp_addr;
    logic [7:0]     s_disp_data;
    logic           s_cpu_req;
    logic           s_cpu_we;
    logic [SAW-1:0] s_cpu_addr;
    logic [7:0]     s_cpu_wdata;
    logic [7:0]     s_cpu_rdata;
    logic           s_cpu_wait;
    logic           s_cpu_ack;
    logic [SAW-1:0] s_ram_addr;
    logic           s_ram_we;
    logic [7:0]     s_ram_wdata;
    logic [7:0]     s_ram_rdata;

    always #5 pixel_clock = ~pixel_clock;

    vram_arbiter dut (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_data   (disp_data),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_wait    (cpu_wait),
        .cpu_ack     (cpu_ack),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    vram_arbiter #(.VRAM_AW(SAW)) dut_small (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .disp_req    (s_disp_req),
        .disp_addr   (s_disp_addr),
        .disp_data   (s_disp_data),
        .cpu_req     (s_cpu_req),
        .cpu_we      (s_cpu_we),
        .cpu_addr    (s_cpu_addr),
        .cpu_wdata   (s_cpu_wdata),
        .cpu_rdata   (s_cpu_rdata),
        .cpu_wait    (s_cpu_wait),
        .cpu_ack     (s_cpu_ack),
        .ram_addr    (s_ram_addr),
        .ram_we      (s_ram_we),
        .ram_wdata   (s_ram_wdata),
        .ram_rdata   (s_ram_rdata)
    );

    function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
        int v;
        if (a == 15'h0010) return 8'h3C;
        if (a == 15'h0020) return 8'h41;
        v = (int'(a) * 29) ^ (int'(a) >> 5) ^ 91;
        return v[7:0];
    endfunction

    // Synchronous RAM, read-before-write within a cycle.
    logic [7:0] mem       [0:(1<<AW)-1];
    bit         mem_valid [0:(1<<AW)-1];
    always @(posedge pixel_clock) begin
        ram_rdata <= mem_valid[ram_addr] ? mem[ram_addr] : init_byte(ram_addr);
        if (ram_we) begin
            mem[ram_addr]       <= ram_wdata;
            mem_valid[ram_addr] <= 1'b1;
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: memory image in slot order plus per-cycle expectations.
    logic [7:0]    ref_mem [0:(1<<AW)-1];
    bit            exp_ack [MAXC];
    bit            exp_we  [MAXC];
    bit            disp_upd[MAXC];
    bit            rd_upd  [MAXC];
    logic [AW-1:0] exp_addr[MAXC];
    logic [7:0]    exp_wd  [MAXC];
    logic [7:0]    disp_val[MAXC];
    logic [7:0]    rd_val  [MAXC];
    logic [7:0]    cur_disp, cur_rd;
    logic [AW-1:0] last_addr;
    bit            active, issued;
    int            ack_cyc;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_wd;
    int            last_ack_cyc;

    task automatic model_reset();
        for (int i = 0; i < MAXC; i++) begin
            exp_ack[i]  = 1'b0;
            exp_we[i]   = 1'b0;
            disp_upd[i] = 1'b0;
            rd_upd[i]   = 1'b0;
        end
        exp_addr[0] = '0;
        cyc       = 0;
        active    = 1'b0;
        issued    = 1'b0;
        ack_cyc   = -1;
        last_addr = '0;
        cur_disp  = '0;
        cur_rd    = '0;
    endtask

    // Entered just after a rising edge; returns just after the next one.
    task automatic cycle(input bit d, input logic [AW-1:0] da, input bit cr, input bit cw,
                         input logic [AW-1:0] ca, input logic [7:0] cd);
        bit exp_wait;
        disp_req  = d;
        disp_addr = da;
        cpu_req   = cr;
        cpu_we    = cw;
        cpu_addr  = ca;
        cpu_wdata = cd;

        if (active && issued && cyc > ack_cyc) active = 1'b0;
        exp_wait = cr || (active && !(issued && cyc == ack_cyc));

        if (d) begin
            last_addr          = da;
            disp_upd[cyc + 3]  = 1'b1;
            disp_val[cyc + 3]  = ref_mem[da];
        end else if (active && !issued) begin
            issued            = 1'b1;
            last_addr         = m_addr;
            exp_we[cyc + 1]   = m_we;
            if (m_we) begin
                exp_wd[cyc + 1] = m_wd;
                ref_mem[m_addr] = m_wd;
                ack_cyc         = cyc + 2;
            end else begin
                rd_upd[cyc + 3] = 1'b1;
                rd_val[cyc + 3] = ref_mem[m_addr];
                ack_cyc         = cyc + 3;
            end
            exp_ack[ack_cyc] = 1'b1;
        end
        exp_addr[cyc + 1] = last_addr;

        if (cr && !active) begin
            active = 1'b1;
            issued = 1'b0;
            m_we   = cw;
            m_addr = ca;
            m_wd   = cd;
        end

        @(negedge pixel_clock);
        if (disp_upd[cyc]) cur_disp = disp_val[cyc];
        if (rd_upd[cyc])   cur_rd   = rd_val[cyc];
        check_eq("cpu_wait",  32'(cpu_wait),  32'(exp_wait));
        check_eq("cpu_ack",   32'(cpu_ack),   32'(exp_ack[cyc]));
        check_eq("ram_we",    32'(ram_we),    32'(exp_we[cyc]));
        check_eq("ram_addr",  32'(ram_addr),  32'(exp_addr[cyc]));
        if (exp_we[cyc]) check_eq("ram_wdata", 32'(ram_wdata), 32'(exp_wd[cyc]));
        check_eq("disp_data", 32'(disp_data), 32'(cur_disp));
        check_eq("cpu_rdata", 32'(cpu_rdata), 32'(cur_rd));
        if (cpu_ack) last_ack_cyc = cyc;
        @(posedge pixel_clock);
        #1;
        cyc++;
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 8'h00);
    endtask

    initial begin
        int            req_cyc;
        int            s_acks;
        bit            rd, rc, rw;
        logic [AW-1:0] ra, rca;
        logic [7:0]    saved;
        logic [15:0]   wide_addr;

        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_byte(AW'(i));

        reset_n     = 1'b0;
        disp_req    = 1'b0;
        disp_addr   = '0;
        cpu_req     = 1'b1;
        cpu_we      = 1'b1;
        cpu_addr    = 15'h1234;
        cpu_wdata   = 8'hFF;
        s_disp_req  = 1'b0;
        s_disp_addr = '0;
        s_cpu_req   = 1'b0;
        s_cpu_we    = 1'b0;
        s_cpu_addr  = '0;
        s_cpu_wdata = '0;
        s_ram_rdata = 8'h00;
        model_reset();

        #3;
        check_eq("rst_ram_we",    32'(ram_we),    32'd0);
        check_eq("rst_ram_addr",  32'(ram_addr),  32'd0);
        check_eq("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check_eq("rst_cpu_ack",   32'(cpu_ack),   32'd0);
        check_eq("rst_cpu_wait",  32'(cpu_wait),  32'd0);
        @(posedge pixel_clock);
        #1;
        check_eq("rst_disp_data",  32'(disp_data),   32'd0);
        check_eq("rst_cpu_rdata",  32'(cpu_rdata),   32'd0);
        check_eq("rst_s_disp",     32'(s_disp_data), 32'd0);
        check_eq("rst_s_rdata",    32'(s_cpu_rdata), 32'd0);
        check_eq("rst_ram_we_clk", 32'(ram_we),      32'd0);
        reset_n = 1'b1;

        // Uncontended write: ack three cycles after the request.
        last_ack_cyc = -100;
        req_cyc = cyc;
        cycle(1'b0, '0, 1'b1, 1'b1, 15'h7000, 8'hA5);
        repeat (4) idle();
        check_eq("wr_ack_lat", 32'(last_ack_cyc - req_cyc), 32'd3);

        // Uncontended read of preloaded data.
        last_ack_cyc = -100;
        req_cyc = cyc;
        cycle(1'b0, '0, 1'b1, 1'b0, 15'h0010, 8'h00);
        repeat (5) idle();
        check_eq("rd_ack_lat", 32'(last_ack_cyc - req_cyc), 32'd4);
        check_eq("rd_data",    32'(cpu_rdata),              32'h3C);

        // Single display fetch, held afterwards.
        cycle(1'b1, 15'h0020, 1'b0, 1'b0, '0, 8'h00);
        repeat (5) idle();
        check_eq("disp_fetch", 32'(disp_data), 32'h41);

        // Pending write stalled by three back-to-back display fetches.
        last_ack_cyc = -100;
        req_cyc = cyc;
        cycle(1'b0, '0, 1'b1, 1'b1, 15'h0200, 8'hC3);
        cycle(1'b1, 15'h0100, 1'b0, 1'b0, '0, 8'h00);
        cycle(1'b1, 15'h0101, 1'b0, 1'b0, '0, 8'h00);
        cycle(1'b1, 15'h0102, 1'b0, 1'b0, '0, 8'h00);
        repeat (4) idle();
        check_eq("contend_ack_lat", 32'(last_ack_cyc - req_cyc), 32'd6);
        check_eq("contend_disp",    32'(disp_data),              32'(init_byte(15'h0102)));

        // Display read in the slot right after a CPU write to the same address.
        cycle(1'b0, '0, 1'b1, 1'b1, 15'h0300, 8'h9E);
        idle();
        cycle(1'b1, 15'h0300, 1'b0, 1'b0, '0, 8'h00);
        repeat (4) idle();
        check_eq("raw_disp", 32'(disp_data), 32'h9E);

        for (int i = 0; i < 1500; i++) begin
            rd  = ($urandom_range(0, 99) < 45);
            rc  = ($urandom_range(0, 99) < 30);
            rw  = $urandom_range(0, 1) == 1;
            ra  = AW'($urandom_range(0, 63));
            rca = AW'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) rca = AW'($urandom);
            cycle(rd, ra, rc, rw, rca, 8'($urandom));
        end
        repeat (6) idle();

        // Reset in the ISSUED cycle of a write.
        saved = ref_mem[15'h0444];
        cycle(1'b0, '0, 1'b1, 1'b1, 15'h0444, 8'hEE);
        idle();
        check_eq("issued_we", 32'(ram_we), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_async_we",   32'(ram_we),   32'd0);
        check_eq("rst_async_ack",  32'(cpu_ack),  32'd0);
        check_eq("rst_async_wait", 32'(cpu_wait), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge pixel_clock);
            #1;
            check_eq("rst_hold_ack", 32'(cpu_ack), 32'd0);
            check_eq("rst_hold_we",  32'(ram_we),  32'd0);
        end
        reset_n = 1'b1;
        ref_mem[15'h0444] = saved;
        model_reset();

        last_ack_cyc = -100;
        req_cyc = cyc;
        cycle(1'b0, '0, 1'b1, 1'b1, 15'h0055, 8'h12);
        repeat (4) idle();
        check_eq("post_rst_wr_lat", 32'(last_ack_cyc - req_cyc), 32'd3);
        cycle(1'b0, '0, 1'b1, 1'b0, 15'h0055, 8'h00);
        repeat (5) idle();
        check_eq("post_rst_rd", 32'(cpu_rdata), 32'h12);
        cycle(1'b0, '0, 1'b1, 1'b0, 15'h0444, 8'h00);
        repeat (5) idle();
        check_eq("aborted_wr", 32'(cpu_rdata), 32'(saved));

        // Narrow instance: address wraps to 11 bits, second request in PEND ignored.
        s_acks = 0;
        wide_addr = 16'h0805;
        s_cpu_req   = 1'b1;
        s_cpu_we    = 1'b1;
        s_cpu_addr  = wide_addr[SAW-1:0];
        s_cpu_wdata = 8'h77;
        s_acks += int'(s_cpu_ack);
        idle();
        s_cpu_req   = 1'b1;
        s_cpu_we    = 1'b1;
        s_cpu_addr  = 11'h123;
        s_cpu_wdata = 8'h99;
        check_eq("s_wait_pend", 32'(s_cpu_wait), 32'd1);
        s_acks += int'(s_cpu_ack);
        idle();
        s_cpu_req = 1'b0;
        check_eq("s_issued_we",   32'(s_ram_we),    32'd1);
        check_eq("s_wrap_addr",   32'(s_ram_addr),  32'h005);
        check_eq("s_buf_wdata",   32'(s_ram_wdata), 32'h77);
        for (int i = 0; i < 8; i++) begin
            s_acks += int'(s_cpu_ack);
            idle();
        end
        check_eq("s_ack_count", 32'(s_acks), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
